// File: rtl/ftoi.sv
// ----------------------------------------------------------------------------
// ftoi: pipelined IEEE-754 single-precision float to 32-bit signed integer.
//
// Rounds to nearest with ties away from zero (guard bit only, sticky bits are
// ignored), saturates out-of-range inputs and flags the saturation on ovf.
// One operand per cycle; a result appears three edges after acceptance.
//
// Ports
//   clk        rising-edge clock
//   rstn       synchronous active-low reset
//   in_valid   x holds an operand this cycle
//   in_ready   operand is accepted this cycle (combinational)
//   x          float operand {sign, exp[7:0], man[22:0]}
//   out_valid  y/ovf hold a result
//   out_ready  consumer takes the result this cycle
//   y          signed integer result
//   ovf        result saturated, or the input was NaN
//
// Pipeline (all stages advance together, or all hold):
//   capture  : operand register
//   S1       : sign/exponent/mantissa plus a class code
//   S2       : 31-bit shifted magnitude plus guard bit
//   S3       : round, negate, saturate into y/ovf
// ----------------------------------------------------------------------------
module ftoi (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        ovf
);

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,   // |x| < 0.5, zeros and denormals
        CLS_HALF = 3'd1,   // |x| in [0.5, 1): rounds to magnitude 1
        CLS_SHR  = 3'd2,   // exponent 127..149: right shift plus guard
        CLS_SHL  = 3'd3,   // exponent 150..157: exact left shift
        CLS_SAT  = 3'd4,   // exponent >= 158 including infinities
        CLS_NAN  = 3'd5
    } cls_t;

    // The whole pipeline moves only when the output slot is free or drained.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = rstn && advance;

    // ---------------- capture stage ----------------
    logic        cap_valid_reg;
    logic [31:0] cap_x_reg;

    // ---------------- S1: classify ----------------
    logic        s1_valid_reg;
    logic        s1_s_reg;
    logic [7:0]  s1_e_reg;
    logic [22:0] s1_m_reg;
    cls_t        s1_cls_reg;
    logic        s1_min_reg;    // operand is exactly -2^31

    logic [7:0]  cap_e;
    cls_t        cls_next;

    always_comb begin
        cap_e    = cap_x_reg[30:23];
        cls_next = CLS_SAT;
        if (cap_e == 8'hFF && cap_x_reg[22:0] != 23'd0)
            cls_next = CLS_NAN;
        else if (cap_e < 8'd126)
            cls_next = CLS_ZERO;
        else if (cap_e == 8'd126)
            cls_next = CLS_HALF;
        else if (cap_e <= 8'd149)
            cls_next = CLS_SHR;
        else if (cap_e <= 8'd157)
            cls_next = CLS_SHL;
    end

    // ---------------- S2: shift ----------------
    logic        s2_valid_reg;
    logic        s2_s_reg;
    cls_t        s2_cls_reg;
    logic        s2_min_reg;
    logic [30:0] s2_mag_reg;
    logic        s2_guard_reg;

    logic [23:0] s1_sig;
    logic [4:0]  rshift;
    logic [2:0]  lshift;
    logic [23:0] shr_pre;
    logic [30:0] mag_next;
    logic        guard_next;

    always_comb begin
        s1_sig     = {1'b1, s1_m_reg};
        // Shifting by one less than the final amount leaves the guard bit
        // in bit 0; the magnitude is then the remaining upper bits.
        rshift     = 5'(8'd149 - s1_e_reg);
        lshift     = 3'(s1_e_reg - 8'd150);
        shr_pre    = s1_sig >> rshift;
        mag_next   = '0;
        guard_next = 1'b0;
        case (s1_cls_reg)
            CLS_HALF: guard_next = 1'b1;    // 0 + round-up gives 1
            CLS_SHR: begin
                mag_next   = {8'd0, shr_pre[23:1]};
                guard_next = shr_pre[0];
            end
            CLS_SHL:  mag_next = {7'd0, s1_sig} << lshift;
            default:  ;
        endcase
    end

    // ---------------- S3: round / negate / saturate ----------------
    logic        out_valid_reg;
    logic [31:0] y_reg;
    logic        ovf_reg;

    logic [31:0] rounded;
    logic [31:0] y_next;
    logic        ovf_next;

    always_comb begin
        // Largest in-range magnitude is 0x7FFFFF80, so the increment
        // cannot carry into the sign bit.
        rounded  = {1'b0, s2_mag_reg} + {31'd0, s2_guard_reg};
        y_next   = s2_s_reg ? (~rounded + 32'd1) : rounded;
        ovf_next = 1'b0;
        case (s2_cls_reg)
            CLS_SAT: begin
                y_next   = s2_s_reg ? 32'h8000_0000 : 32'h7FFF_FFFF;
                // -2^31 itself is representable, so it is not an overflow.
                ovf_next = !(s2_s_reg && s2_min_reg);
            end
            CLS_NAN: begin
                y_next   = 32'h7FFF_FFFF;
                ovf_next = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- state ----------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cap_valid_reg <= 1'b0;
            cap_x_reg     <= '0;
            s1_valid_reg  <= 1'b0;
            s1_s_reg      <= 1'b0;
            s1_e_reg      <= '0;
            s1_m_reg      <= '0;
            s1_cls_reg    <= CLS_ZERO;
            s1_min_reg    <= 1'b0;
            s2_valid_reg  <= 1'b0;
            s2_s_reg      <= 1'b0;
            s2_cls_reg    <= CLS_ZERO;
            s2_min_reg    <= 1'b0;
            s2_mag_reg    <= '0;
            s2_guard_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            y_reg         <= '0;
            ovf_reg       <= 1'b0;
        end else if (advance) begin
            cap_valid_reg <= in_valid;
            if (in_valid)
                cap_x_reg <= x;

            s1_valid_reg <= cap_valid_reg;
            s1_s_reg     <= cap_x_reg[31];
            s1_e_reg     <= cap_x_reg[30:23];
            s1_m_reg     <= cap_x_reg[22:0];
            s1_cls_reg   <= cls_next;
            s1_min_reg   <= (cap_x_reg == 32'hCF00_0000);

            s2_valid_reg <= s1_valid_reg;
            s2_s_reg     <= s1_s_reg;
            s2_cls_reg   <= s1_cls_reg;
            s2_min_reg   <= s1_min_reg;
            s2_mag_reg   <= mag_next;
            s2_guard_reg <= guard_next;

            out_valid_reg <= s2_valid_reg;
            // Bubbles leave y/ovf at their last values.
            if (s2_valid_reg) begin
                y_reg   <= y_next;
                ovf_reg <= ovf_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign y         = y_reg;
    assign ovf       = ovf_reg;

endmodule
